// File: rtl/rob_ring.sv
// rob_ring: circular reorder buffer, in-order retire, tag shootdown,
// precise-exception flush. Ports: alloc_* dispatch, wb_* completion,
// retire_* commit, shootdown*, exc_* fault report, free_count/empty/full.
module rob_ring #(
  parameter int ROB_ENTRIES    = 16,
  parameter int DISPATCH_WIDTH = 2,
  parameter int RETIRE_WIDTH   = 2,
  parameter int WB_PORTS       = 2,
  parameter int AREG_BITS      = 4,
  parameter int PREG_BITS      = 6,
  parameter int TAG_BITS       = 2,
  localparam int IDX_BITS      = $clog2(ROB_ENTRIES)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                clear,
  input  logic [DISPATCH_WIDTH-1:0]           alloc_req,
  input  logic [DISPATCH_WIDTH*AREG_BITS-1:0] alloc_areg,
  input  logic [DISPATCH_WIDTH*PREG_BITS-1:0] alloc_preg,
  input  logic [DISPATCH_WIDTH*PREG_BITS-1:0] alloc_old_preg,
  input  logic [DISPATCH_WIDTH-1:0]           alloc_zerocycle,
  input  logic [DISPATCH_WIDTH*TAG_BITS-1:0]  alloc_tag,
  output logic                                alloc_ready,
  output logic [DISPATCH_WIDTH*IDX_BITS-1:0]  alloc_idx,
  input  logic [WB_PORTS-1:0]                 wb_valid,
  input  logic [WB_PORTS*IDX_BITS-1:0]        wb_idx,
  input  logic [WB_PORTS-1:0]                 wb_exception,
  input  logic                                retire_ready,
  output logic [RETIRE_WIDTH-1:0]             retire_valid,
  output logic [RETIRE_WIDTH*AREG_BITS-1:0]   retire_areg,
  output logic [RETIRE_WIDTH*PREG_BITS-1:0]   retire_preg,
  output logic [RETIRE_WIDTH*PREG_BITS-1:0]   retire_old_preg,
  input  logic                                shootdown,
  input  logic [TAG_BITS-1:0]                 shootdown_tag,
  output logic                                exc_valid,
  output logic [IDX_BITS-1:0]                 exc_idx,
  output logic [IDX_BITS:0]                   free_count,
  output logic                                empty,
  output logic                                full
);

  localparam int CW = IDX_BITS + 1;
  typedef logic [IDX_BITS-1:0] idx_t;
  typedef logic [CW-1:0]       cnt_t;

  logic [ROB_ENTRIES-1:0] vld_q, vld_d;
  logic [ROB_ENTRIES-1:0] bsy_q, bsy_d;
  logic [ROB_ENTRIES-1:0] exc_q, exc_d;
  logic [AREG_BITS-1:0]   areg_q  [ROB_ENTRIES];
  logic [PREG_BITS-1:0]   preg_q  [ROB_ENTRIES];
  logic [PREG_BITS-1:0]   opreg_q [ROB_ENTRIES];
  logic [TAG_BITS-1:0]    tag_q   [ROB_ENTRIES];
  idx_t head_q, head_d;
  idx_t tail_q, tail_d;
  cnt_t cnt_q, cnt_d;

  cnt_t n_alloc, n_ret, sq_off;
  logic sq_hit, flush, ok;
  logic [ROB_ENTRIES-1:0] sq_mask;
  idx_t rel, ri, wi, ti;

  assign free_count = cnt_t'(ROB_ENTRIES) - cnt_q;
  assign empty      = (cnt_q == '0);
  assign full       = (free_count == '0);
  assign exc_idx    = head_q;
  assign exc_valid  = vld_q[head_q] & ~bsy_q[head_q]
                    & exc_q[head_q] & retire_ready;
  assign flush      = clear | exc_valid;

  // First live entry (from head) younger than the surviving tag;
  // everything from there to the tail is squashed.
  always_comb begin
    sq_hit  = 1'b0;
    sq_off  = '0;
    rel     = '0;
    sq_mask = '0;
    for (int j = ROB_ENTRIES-1; j >= 0; j--) begin
      if (shootdown && cnt_t'(j) < cnt_q &&
          tag_q[head_q + idx_t'(j)] > shootdown_tag) begin
        sq_hit = 1'b1;
        sq_off = cnt_t'(j);
      end
    end
    for (int k = 0; k < ROB_ENTRIES; k++) begin
      rel = idx_t'(k) - head_q;
      sq_mask[k] = sq_hit && cnt_t'(rel) >= sq_off
                && cnt_t'(rel) < cnt_q;
    end
  end

  // Retire window: contiguous done entries from head; squashed
  // entries never retire even if complete.
  always_comb begin
    ok    = 1'b1;
    n_ret = '0;
    ri    = '0;
    for (int j = 0; j < RETIRE_WIDTH; j++) begin
      ri = head_q + idx_t'(j);
      ok = ok & vld_q[ri] & ~bsy_q[ri]
         & ~exc_q[ri] & ~sq_mask[ri];
      retire_valid[j] = ok;
      retire_areg[j*AREG_BITS +: AREG_BITS]     = areg_q[ri];
      retire_preg[j*PREG_BITS +: PREG_BITS]     = preg_q[ri];
      retire_old_preg[j*PREG_BITS +: PREG_BITS] = opreg_q[ri];
      if (ok && retire_ready) n_ret = n_ret + cnt_t'(1);
    end
  end

  always_comb begin
    n_alloc = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      n_alloc = n_alloc + cnt_t'(alloc_req[i]);
      alloc_idx[i*IDX_BITS +: IDX_BITS] = tail_q + idx_t'(i);
    end
    alloc_ready = (n_alloc <= free_count)
                && !shootdown && !exc_valid;
  end

  always_comb begin
    vld_d = vld_q;
    bsy_d = bsy_q;
    exc_d = exc_q;
    wi    = '0;
    ti    = '0;
    for (int w = 0; w < WB_PORTS; w++) begin
      wi = wb_idx[w*IDX_BITS +: IDX_BITS];
      if (wb_valid[w] && vld_q[wi] && !sq_mask[wi]) begin
        bsy_d[wi] = 1'b0;
        exc_d[wi] = exc_d[wi] | wb_exception[w];
      end
    end
    for (int j = 0; j < RETIRE_WIDTH; j++) begin
      if (retire_ready && retire_valid[j])
        vld_d[head_q + idx_t'(j)] = 1'b0;
    end
    vld_d = vld_d & ~sq_mask;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (alloc_ready && alloc_req[i]) begin
        ti = tail_q + idx_t'(i);
        vld_d[ti] = 1'b1;
        bsy_d[ti] = ~alloc_zerocycle[i];
        exc_d[ti] = 1'b0;
      end
    end
    head_d = head_q + n_ret[IDX_BITS-1:0];
    if (sq_hit)
      tail_d = head_q + sq_off[IDX_BITS-1:0];
    else if (alloc_ready)
      tail_d = tail_q + n_alloc[IDX_BITS-1:0];
    else
      tail_d = tail_q;
    cnt_d = cnt_q - n_ret
          - (sq_hit ? cnt_q - sq_off : '0)
          + (alloc_ready ? n_alloc : '0);
    if (flush) begin
      vld_d  = '0;
      bsy_d  = '0;
      exc_d  = '0;
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q  <= '0;
      bsy_q  <= '0;
      exc_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      bsy_q  <= bsy_d;
      exc_q  <= exc_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < ROB_ENTRIES; k++) begin
        areg_q[k]  <= '0;
        preg_q[k]  <= '0;
        opreg_q[k] <= '0;
        tag_q[k]   <= '0;
      end
    end else begin
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
        if (alloc_ready && alloc_req[i]) begin
          areg_q[tail_q + idx_t'(i)] <=
            alloc_areg[i*AREG_BITS +: AREG_BITS];
          preg_q[tail_q + idx_t'(i)] <=
            alloc_preg[i*PREG_BITS +: PREG_BITS];
          opreg_q[tail_q + idx_t'(i)] <=
            alloc_old_preg[i*PREG_BITS +: PREG_BITS];
          tag_q[tail_q + idx_t'(i)] <=
            alloc_tag[i*TAG_BITS +: TAG_BITS];
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_ring.sv
// tb_rob_ring: directed + random checks of rob_ring against a
// queue-based program-order model of the reorder buffer.
module tb_rob_ring;

  localparam int N   = 16;
  localparam int DW  = 2;
  localparam int RW  = 2;
  localparam int WB  = 2;
  localparam int AB  = 4;
  localparam int PB  = 6;
  localparam int TGB = 2;
  localparam int IB  = 4;

  logic clk = 1'b0;
  logic reset, clear;
  logic [DW-1:0]     alloc_req, alloc_zerocycle;
  logic [DW*AB-1:0]  alloc_areg;
  logic [DW*PB-1:0]  alloc_preg, alloc_old_preg;
  logic [DW*TGB-1:0] alloc_tag;
  logic              alloc_ready;
  logic [DW*IB-1:0]  alloc_idx;
  logic [WB-1:0]     wb_valid, wb_exception;
  logic [WB*IB-1:0]  wb_idx;
  logic              retire_ready;
  logic [RW-1:0]     retire_valid;
  logic [RW*AB-1:0]  retire_areg;
  logic [RW*PB-1:0]  retire_preg, retire_old_preg;
  logic              shootdown;
  logic [TGB-1:0]    shootdown_tag;
  logic              exc_valid;
  logic [IB-1:0]     exc_idx;
  logic [IB:0]       free_count;
  logic              empty, full;

  rob_ring dut (
    .clk(clk), .reset(reset), .clear(clear),
    .alloc_req(alloc_req), .alloc_areg(alloc_areg),
    .alloc_preg(alloc_preg), .alloc_old_preg(alloc_old_preg),
    .alloc_zerocycle(alloc_zerocycle), .alloc_tag(alloc_tag),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx),
    .wb_exception(wb_exception), .retire_ready(retire_ready),
    .retire_valid(retire_valid), .retire_areg(retire_areg),
    .retire_preg(retire_preg), .retire_old_preg(retire_old_preg),
    .shootdown(shootdown), .shootdown_tag(shootdown_tag),
    .exc_valid(exc_valid), .exc_idx(exc_idx),
    .free_count(free_count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int areg, preg, opreg, tag;
    bit busy, exc;
  } ent_t;

  ent_t q[$];
  int   mhead = 0;
  int   nchk  = 0;
  int   nerr  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    clear           = 1'b0;
    alloc_req       = '0;
    alloc_zerocycle = '0;
    alloc_areg      = '0;
    alloc_preg      = '0;
    alloc_old_preg  = '0;
    alloc_tag       = '0;
    wb_valid        = '0;
    wb_idx          = '0;
    wb_exception    = '0;
    retire_ready    = 1'b0;
    shootdown       = 1'b0;
    shootdown_tag   = '0;
  endtask

  task automatic setslot(input int i, input int a, input int p,
                         input int op, input bit zc, input int t);
    alloc_req[i]              = 1'b1;
    alloc_zerocycle[i]        = zc;
    alloc_areg[i*AB +: AB]    = AB'(a);
    alloc_preg[i*PB +: PB]    = PB'(p);
    alloc_old_preg[i*PB +: PB] = PB'(op);
    alloc_tag[i*TGB +: TGB]   = TGB'(t);
  endtask

  task automatic setwb(input int w, input int idx, input bit ex);
    wb_valid[w]         = 1'b1;
    wb_idx[w*IB +: IB]  = IB'(idx);
    wb_exception[w]     = ex;
  endtask

  // Check outputs against the model, then advance the model by one edge.
  task automatic cycle();
    int sz, off, nr, n, k, widx;
    bit exe, rdy;
    ent_t e;
    @(negedge clk);
    sz  = q.size();
    exe = sz > 0 && !q[0].busy && q[0].exc && retire_ready;
    off = sz;
    if (shootdown)
      for (int i = 0; i < sz; i++)
        if (off == sz && q[i].tag > int'(shootdown_tag)) off = i;
    nr = 0;
    for (int i = 0; i < RW; i++)
      if (nr == i && i < off && !q[i].busy && !q[i].exc) nr++;
    n = 0;
    for (int i = 0; i < DW; i++) n += int'(alloc_req[i]);
    rdy = (n <= N - sz) && !shootdown && !exe;

    chk("alloc_ready", 32'(alloc_ready), 32'(rdy));
    for (int i = 0; i < DW; i++)
      chk("alloc_idx", 32'(alloc_idx[i*IB +: IB]), (mhead + sz + i) % N);
    chk("retire_valid", 32'(retire_valid), (1 << nr) - 1);
    for (int i = 0; i < nr; i++) begin
      chk("retire_areg", 32'(retire_areg[i*AB +: AB]), q[i].areg);
      chk("retire_preg", 32'(retire_preg[i*PB +: PB]), q[i].preg);
      chk("retire_old", 32'(retire_old_preg[i*PB +: PB]), q[i].opreg);
    end
    chk("exc_valid", 32'(exc_valid), 32'(exe));
    if (exe) chk("exc_idx", 32'(exc_idx), mhead);
    chk("free_count", 32'(free_count), N - sz);
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full", 32'(full), 32'(sz == N));

    if (clear || exe) begin
      q.delete();
      mhead = 0;
    end else begin
      for (int w = 0; w < WB; w++) begin
        if (wb_valid[w]) begin
          widx = int'(wb_idx[w*IB +: IB]);
          k = (widx - mhead + N) % N;
          if (k < off) begin
            e = q[k];
            e.busy = 1'b0;
            e.exc  = e.exc | wb_exception[w];
            q[k] = e;
          end
        end
      end
      while (q.size() > off) void'(q.pop_back());
      if (retire_ready) begin
        repeat (nr) void'(q.pop_front());
        mhead = (mhead + nr) % N;
      end
      if (rdy)
        for (int i = 0; i < n; i++) begin
          e.areg  = int'(alloc_areg[i*AB +: AB]);
          e.preg  = int'(alloc_preg[i*PB +: PB]);
          e.opreg = int'(alloc_old_preg[i*PB +: PB]);
          e.tag   = int'(alloc_tag[i*TGB +: TGB]);
          e.busy  = !alloc_zerocycle[i];
          e.exc   = 1'b0;
          q.push_back(e);
        end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    idle();
    clear = 1'b1;
    cycle();
  endtask

  initial begin
    int base, tg, na, sz, wi;
    reset = 1'b0;
    idle();
    #12;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_free", 32'(free_count), 16);
    chk("rst_retv", 32'(retire_valid), 0);
    chk("rst_ready", 32'(alloc_ready), 1);
    chk("rst_exc", 32'(exc_valid), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // two zero-cycle entries retire the next cycle
    idle();
    retire_ready = 1'b1;
    setslot(0, 1, 10, 20, 1'b1, 0);
    setslot(1, 2, 11, 21, 1'b1, 0);
    #1;
    chk("t1_idx0", 32'(alloc_idx[0 +: IB]), 0);
    chk("t1_idx1", 32'(alloc_idx[IB +: IB]), 1);
    cycle();
    idle();
    retire_ready = 1'b1;
    #1;
    chk("t1_retv", 32'(retire_valid), 3);
    chk("t1_rp0", 32'(retire_preg[0 +: PB]), 10);
    chk("t1_rp1", 32'(retire_preg[PB +: PB]), 11);
    cycle();
    idle();
    #1;
    chk("t1_empty", 32'(empty), 1);

    // fill, refuse, then wrap-around allocation at idx 0
    do_clear();
    for (int c = 0; c < 8; c++) begin
      idle();
      setslot(0, c, 2 * c, 40 + c, 1'b0, 0);
      setslot(1, c + 1, 2 * c + 1, 50 + c, 1'b0, 0);
      cycle();
    end
    idle();
    setslot(0, 3, 3, 3, 1'b0, 0);
    setslot(1, 4, 4, 4, 1'b0, 0);
    #1;
    chk("t2_full", 32'(full), 1);
    chk("t2_refuse", 32'(alloc_ready), 0);
    cycle();
    idle();
    setwb(0, 0, 1'b0);
    cycle();
    idle();
    retire_ready = 1'b1;
    cycle();
    idle();
    #1;
    chk("t2_free1", 32'(free_count), 1);
    setslot(0, 5, 5, 5, 1'b0, 0);
    setslot(1, 6, 6, 6, 1'b0, 0);
    #1;
    chk("t2_refuse2", 32'(alloc_ready), 0);
    cycle();
    idle();
    setslot(0, 7, 7, 7, 1'b0, 0);
    #1;
    chk("t2_wrap_rdy", 32'(alloc_ready), 1);
    chk("t2_wrap_idx", 32'(alloc_idx[0 +: IB]), 0);
    cycle();

    // head busy blocks younger completed entries
    do_clear();
    for (int c = 0; c < 2; c++) begin
      idle();
      setslot(0, c, c, c, 1'b0, 0);
      setslot(1, c, c, c, 1'b0, 0);
      cycle();
    end
    idle();
    setwb(0, 1, 1'b0);
    setwb(1, 2, 1'b0);
    cycle();
    idle();
    setwb(0, 3, 1'b0);
    retire_ready = 1'b1;
    #1;
    chk("t3_blocked", 32'(retire_valid), 0);
    cycle();
    idle();
    setwb(0, 0, 1'b0);
    retire_ready = 1'b1;
    cycle();
    for (int c = 0; c < 2; c++) begin
      idle();
      retire_ready = 1'b1;
      #1;
      chk("t3_retv", 32'(retire_valid), 3);
      cycle();
    end

    // shootdown of tags above 0
    do_clear();
    idle();
    setslot(0, 1, 1, 1, 1'b0, 0);
    setslot(1, 2, 2, 2, 1'b0, 0);
    cycle();
    idle();
    setslot(0, 3, 3, 3, 1'b0, 1);
    setslot(1, 4, 4, 4, 1'b0, 2);
    cycle();
    idle();
    setslot(0, 5, 5, 5, 1'b0, 2);
    cycle();
    idle();
    shootdown = 1'b1;
    shootdown_tag = '0;
    cycle();
    idle();
    #1;
    chk("t4_free", 32'(free_count), 14);
    setwb(0, 3, 1'b0);
    cycle();
    idle();
    setslot(0, 6, 6, 6, 1'b0, 0);
    #1;
    chk("t4_idx", 32'(alloc_idx[0 +: IB]), 2);
    cycle();

    // precise exception at head
    do_clear();
    idle();
    setslot(0, 1, 1, 1, 1'b0, 0);
    cycle();
    idle();
    setwb(0, 0, 1'b1);
    cycle();
    idle();
    retire_ready = 1'b1;
    #1;
    chk("t5_exc", 32'(exc_valid), 1);
    chk("t5_exc_idx", 32'(exc_idx), 0);
    chk("t5_retv", 32'(retire_valid), 0);
    cycle();
    idle();
    #1;
    chk("t5_empty", 32'(empty), 1);
    chk("t5_tail", 32'(alloc_idx[0 +: IB]), 0);

    // async reset mid-cycle with 5 live entries
    for (int c = 0; c < 3; c++) begin
      idle();
      setslot(0, c, c, c, 1'b0, 0);
      if (c < 2) setslot(1, c, c, c, 1'b0, 0);
      cycle();
    end
    idle();
    #1;
    reset = 1'b0;
    #1;
    chk("ar_empty", 32'(empty), 1);
    chk("ar_free", 32'(free_count), 16);
    chk("ar_full", 32'(full), 0);
    chk("ar_ready", 32'(alloc_ready), 1);
    reset = 1'b1;
    q.delete();
    mhead = 0;
    cycle();

    // clear beats a simultaneous allocation
    idle();
    clear = 1'b1;
    setslot(0, 1, 1, 1, 1'b1, 0);
    setslot(1, 2, 2, 2, 1'b1, 0);
    cycle();
    idle();
    #1;
    chk("clr_empty", 32'(empty), 1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      clear = ($urandom % 64) == 0;
      shootdown = ($urandom % 10) == 0;
      shootdown_tag = TGB'($urandom);
      retire_ready = ($urandom % 4) != 0;
      base = q.size() > 0 ? q[$].tag : 0;
      tg = base;
      na = int'($urandom % 3);
      for (int i = 0; i < na; i++) begin
        if (tg < 3 && ($urandom % 4) == 0) tg++;
        setslot(i, int'($urandom % 16), int'($urandom % 64),
                int'($urandom % 64), ($urandom % 3) == 0, tg);
      end
      sz = q.size();
      for (int w = 0; w < WB; w++) begin
        if (($urandom % 2) == 0) begin
          if (sz > 0 && ($urandom % 8) != 0)
            wi = (mhead + int'($urandom % sz)) % N;
          else
            wi = int'($urandom % N);
          setwb(w, wi, ($urandom % 16) == 0);
        end
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
